// File: rtl/replica_pkg.sv
// Shared types for the replica annealing datapath.
// Move encoding, city count and RNG state type.
package replica_pkg;

    // Number of cities in the tour; legal city indices are 1..city_num-1.
    localparam int city_num = 30;

    // THR encodes as 0 and is never proposed.
    typedef enum logic [1:0] {
        THR = 2'd0,
        TWO = 2'd1,
        OR0 = 2'd2,
        OR1 = 2'd3
    } opt_command;

    typedef struct packed {
        opt_command command;
        logic [6:0] k;
        logic [6:0] l;
    } opt_t;

    typedef logic [31:0] rng_state_t;

endpackage

// File: rtl/xorshift32.sv
// xorshift32 next-state function (combinational).
// Ports: i_x current state, o_x next state.
module xorshift32
    import replica_pkg::*;
(
    input  rng_state_t i_x,
    output rng_state_t o_x
);

    rng_state_t w_a;
    rng_state_t w_b;

    assign w_a = i_x ^ (i_x << 13);
    assign w_b = w_a ^ (w_a >> 17);
    assign o_x = w_b ^ (w_b << 5);

endmodule

// File: rtl/opt_generator.sv
// Random move proposer: decodes xorshift32 state into opt_t,
// drops illegal moves, offers legal ones over valid/ready.
// Ports: clk, rst_n (sync, active-low), enable, seed_we, seed_i,
//        opt_valid, opt_ready, opt_o {command,K,L}, reject_cnt.
module opt_generator
    import replica_pkg::*;
#(
    parameter rng_state_t SEED     = 32'h2545_F491,
    parameter int         CITY_NUM = city_num
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     seed_we,
    input  logic [31:0]              seed_i,
    output logic                     opt_valid,
    input  logic                     opt_ready,
    output logic [$bits(opt_t)-1:0]  opt_o,
    output logic [15:0]              reject_cnt
);

    localparam logic [7:0] MAX_IDX = 8'(CITY_NUM - 1);

    rng_state_t  r_x;
    opt_t        r_opt;
    logic        r_valid;
    logic [15:0] r_reject_cnt;

    rng_state_t  w_x_next;
    opt_t        w_cand;
    logic [7:0]  w_k8;
    logic [7:0]  w_l8;
    logic        w_in_range;
    logic        w_legal;
    logic        w_slot_free;
    logic        w_draw;

    xorshift32 u_rng (
        .i_x (r_x),
        .o_x (w_x_next)
    );

    // Candidate comes from the current state, before it advances.
    always_comb begin
        w_cand         = '0;
        w_cand.command = opt_command'(r_x[1:0]);
        w_cand.k       = r_x[8:2];
        w_cand.l       = r_x[15:9];
    end

    // Widen to 8 bits so L+1 cannot wrap in the OR1 test.
    assign w_k8 = {1'b0, w_cand.k};
    assign w_l8 = {1'b0, w_cand.l};

    assign w_in_range = (w_k8 >= 8'd1) && (w_k8 <= MAX_IDX) &&
                        (w_l8 >= 8'd1) && (w_l8 <= MAX_IDX);

    always_comb begin
        w_legal = 1'b0;
        unique case (w_cand.command)
            TWO, OR0: w_legal = w_in_range && (w_k8 < w_l8);
            OR1:      w_legal = w_in_range && (w_k8 > w_l8 + 8'd1);
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_slot_free = !r_valid || opt_ready;
    assign w_draw      = enable && w_slot_free && !seed_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x          <= SEED;
            r_opt        <= '0;
            r_valid      <= 1'b0;
            r_reject_cnt <= '0;
        end else begin
            // Seed load wins over a draw; a zero seed would lock the RNG.
            if (seed_we) begin
                r_x <= (seed_i == 32'd0) ? SEED : seed_i;
            end else if (w_draw) begin
                r_x <= w_x_next;
            end

            if (w_draw) begin
                if (w_legal) begin
                    r_opt   <= w_cand;
                    r_valid <= 1'b1;
                end else begin
                    if (opt_ready) begin
                        r_valid <= 1'b0;
                    end
                    if (r_reject_cnt != 16'hFFFF) begin
                        r_reject_cnt <= r_reject_cnt + 16'd1;
                    end
                end
            end else if (opt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign opt_valid  = r_valid;
    assign opt_o      = r_opt;
    assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_opt_generator.sv
// Testbench for opt_generator: directed vectors, reference RNG model,
// scoreboard queue popped by an independent monitor.
module tb_opt_generator;
    import replica_pkg::*;

    localparam logic [31:0] SEED = 32'h2545_F491;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        seed_we = 1'b0;
    logic [31:0] seed_i = '0;
    logic        opt_valid;
    logic        opt_ready = 1'b0;
    logic [15:0] opt_o;
    logic [15:0] reject_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc = 0;
    int exp_rej = 0;
    logic [15:0] exp_q[$];

    logic        stall_d = 1'b0;
    logic [15:0] stall_o = '0;

    always #5 clk = ~clk;

    opt_generator #(.SEED(SEED), .CITY_NUM(city_num)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .seed_we    (seed_we),
        .seed_i     (seed_i),
        .opt_valid  (opt_valid),
        .opt_ready  (opt_ready),
        .opt_o      (opt_o),
        .reject_cnt (reject_cnt)
    );

    function automatic logic [31:0] ref_xs(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic bit ref_legal(input logic [31:0] v);
        int c;
        int k;
        int l;
        c = int'(v[1:0]);
        k = int'(v[8:2]);
        l = int'(v[15:9]);
        if (c == 0) return 1'b0;
        if (k < 1 || k > city_num - 1) return 1'b0;
        if (l < 1 || l > city_num - 1) return 1'b0;
        if (c == 3) return k > l + 1;
        return k < l;
    endfunction

    function automatic logic [15:0] ref_opt(input logic [31:0] v);
        return {v[1:0], v[8:2], v[15:9]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            stall_d = 1'b0;
        end else begin
            if (stall_d) begin
                chk("stall_valid", 32'(opt_valid), 32'd1);
                chk("stall_opt", 32'(opt_o), 32'(stall_o));
            end
            if (opt_valid && opt_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_move: got %h expected none", opt_o);
                end else begin
                    chk("accept_opt", 32'(opt_o), 32'(exp_q.pop_front()));
                end
            end
            stall_d = opt_valid && !opt_ready;
            stall_o = opt_o;
        end
    end

    task automatic load_seed(input logic [31:0] s);
        enable  = 1'b0;
        seed_we = 1'b1;
        seed_i  = s;
        @(negedge clk);
        seed_we = 1'b0;
    endtask

    task automatic draw_once();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic free_run(input logic [31:0] start, input int ncyc,
                            input bit rnd);
        logic [31:0] s;
        int nleg;
        int nill;
        int acc0;
        s = start;
        nleg = 0;
        nill = 0;
        exp_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (ref_legal(s)) begin
                exp_q.push_back(ref_opt(s));
                nleg++;
            end else begin
                nill++;
            end
            s = ref_xs(s);
        end
        acc0 = n_acc;
        for (int i = 0; i < ncyc; i++) begin
            enable = 1'b1;
            opt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        enable = 1'b0;
        opt_ready = 1'b1;
        @(negedge clk);
        opt_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(opt_valid), 32'd0);
        if (!rnd) begin
            chk("acc_count", 32'(n_acc - acc0), 32'(nleg));
            exp_rej += nill;
            chk("run_reject_cnt", 32'(reject_cnt), 32'(exp_rej));
        end else begin
            chk("acc_nonzero", 32'(n_acc - acc0 > 0), 32'd1);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        int acc0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(opt_valid), 32'd0);
        chk("rst_opt", 32'(opt_o), 32'd0);
        chk("rst_rej", 32'(reject_cnt), 32'd0);

        // Idle with enable low: nothing produced, state kept
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (opt_valid) seen = 1'b1;
        end
        chk("idle_no_valid", 32'(seen), 32'd0);
        exp_rej = 0;
        free_run(SEED, 600, 1'b0);

        // Legal TWO,3,10 held under back-pressure
        load_seed(32'h0000_140D);
        enable = 1'b1;
        opt_ready = 1'b0;
        @(negedge clk);
        chk("two_valid", 32'(opt_valid), 32'd1);
        chk("two_opt", 32'(opt_o), 32'h0000_418A);
        repeat (5) @(negedge clk);
        chk("two_hold_valid", 32'(opt_valid), 32'd1);
        chk("two_hold_opt", 32'(opt_o), 32'h0000_418A);
        exp_q.push_back(16'h418A);
        acc0 = n_acc;
        opt_ready = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        opt_ready = 1'b0;
        chk("two_taken", 32'(n_acc - acc0), 32'd1);
        chk("two_cleared", 32'(opt_valid), 32'd0);

        // Rejections: OR1 with K<=L+1, THR, K out of range
        load_seed(32'h0000_1417);
        draw_once();
        exp_rej++;
        chk("or1_rej_cnt", 32'(reject_cnt), 32'(exp_rej));
        chk("or1_rej_valid", 32'(opt_valid), 32'd0);
        load_seed(32'h0000_140C);
        draw_once();
        exp_rej++;
        chk("thr_rej_cnt", 32'(reject_cnt), 32'(exp_rej));
        chk("thr_rej_valid", 32'(opt_valid), 32'd0);
        load_seed(32'h0000_147D);
        draw_once();
        exp_rej++;
        chk("k31_rej_cnt", 32'(reject_cnt), 32'(exp_rej));
        chk("k31_rej_valid", 32'(opt_valid), 32'd0);
        free_run(ref_xs(32'h0000_147D), 600, 1'b0);

        // Zero seed substitutes SEED
        load_seed(32'h0000_0000);
        free_run(SEED, 600, 1'b0);

        // Long run with random back-pressure
        load_seed(32'hC0FF_EE11);
        free_run(32'hC0FF_EE11, 20000, 1'b1);

        // Reset while a move is stalled
        load_seed(32'h0000_140D);
        enable = 1'b1;
        opt_ready = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        chk("pre_rst_valid", 32'(opt_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(opt_valid), 32'd0);
        chk("mid_rst_rej", 32'(reject_cnt), 32'd0);
        chk("mid_rst_opt", 32'(opt_o), 32'd0);
        rst_n = 1'b1;

        // Counter saturation
        force dut.r_reject_cnt = 16'hFFFF;
        #1;
        release dut.r_reject_cnt;
        @(negedge clk);
        chk("sat_preload", 32'(reject_cnt), 32'h0000_FFFF);
        load_seed(32'h0000_1417);
        draw_once();
        chk("sat_hold1", 32'(reject_cnt), 32'h0000_FFFF);
        load_seed(32'h0000_140C);
        draw_once();
        chk("sat_hold2", 32'(reject_cnt), 32'h0000_FFFF);
        chk("sat_valid", 32'(opt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
